mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage data-memory access engine, sitting directly upstream of the MEM/WB pipeline register.
- Takes the decoded memory op, address and store data from EX/MEM and drives a req/ack data bus with variable latency.
- Produces the extended load result (M_dmData) consumed by MEM/WB.
- Raises M_stall while an access is outstanding; MEM/WB enable and all upstream enables are driven by ~M_stall.

Parameters:
BUS_TIMEOUT, 16, cycles in REQ without bus_ack before the access aborts with a bus error (range 1..255)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
M_valid  in  1  MEM-stage instruction valid (0 = bubble)
M_memOp  in  4  0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu, 6 sw, 7 sh, 8 sb; 9-15 treated as none
M_addr  in  32  effective byte address
M_rtData  in  32  store source data
bus_ack  in  1  bus completion strobe, one cycle
bus_rdata  in  32  read word, valid with bus_ack
bus_req  out  1  access request, registered
bus_we  out  1  1 = write
bus_be  out  4  byte enables
bus_addr  out  32  word address {M_addr[31:2],2'b00}
bus_wdata  out  32  lane-replicated store data
M_stall  out  1  freeze pipeline, combinational
M_dmData  out  32  extended load data, registered
M_excAdEL  out  1  misaligned load, combinational
M_excAdES  out  1  misaligned store, combinational
M_busErr  out  1  timeout abort flag, registered

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, cnt=0.
  - bus_req, bus_we, bus_be, bus_addr, bus_wdata, M_dmData and M_busErr all go to 0 immediately.
  - M_stall is forced to 0 while reset is low.
  - Reset mid-access drops bus_req without waiting for ack; a late ack is ignored.
- Alignment rules:
  - lw/sw are misaligned if addr[1:0]!=0.
  - lh/lhu/sh are misaligned if addr[0]!=0.
  - Byte ops are never misaligned.
- Exception outputs:
  - M_excAdEL/M_excAdES = M_valid & (load/store) & misaligned & state==IDLE.
  - A misaligned op causes no bus access and no stall.
- start = M_valid & op!=none & aligned & state==IDLE.
- FSM:
  - IDLE:
    - On start: M_stall=1; register bus_req=1 and bus_we, bus_be, bus_addr, bus_wdata; cnt=0; next state REQ.
    - Otherwise stay in IDLE with M_stall=0.
  - REQ:
    - M_stall=1 and bus_req held.
    - Bus outputs are frozen and cnt increments.
    - On bus_ack:
      - For a load, M_dmData <= extend(bus_rdata); for a store, M_dmData <= 0.
      - bus_req=0, M_busErr=0, next state DONE.
    - On cnt==BUS_TIMEOUT-1 with no ack: bus_req=0, M_dmData=0, M_busErr=1, next state DONE.
    - If ack arrives on the timeout cycle, the ack wins.
  - DONE:
    - M_stall=0, so the pipeline advances at this edge and MEM/WB captures M_dmData.
    - Next state is IDLE; no restart is possible in DONE.
    - bus_be and bus_we are cleared on leaving DONE.
- Latency: start to DONE is 2 cycles minimum (ack on the first REQ cycle), which gives 2 stall cycles. Each extra wait cycle adds one stall.
- Byte enables:
  - sw: 1111.
  - sh: addr[1] ? 1100 : 0011.
  - sb: 0001<<addr[1:0].
  - Loads: 1111.
- Store data:
  - sw: rt.
  - sh: {2{rt[15:0]}}.
  - sb: {4{rt[7:0]}}.
- Load extension:
  - lw: the full word.
  - lh/lhu: half selected by addr[1], sign- or zero-extended.
  - lb/lbu: byte selected by addr[1:0], sign- or zero-extended.
- bus_ack outside REQ is ignored.
- M_memOp, M_addr and M_rtData may change during REQ (upstream is frozen, but this block does not rely on it): operands are latched at start, and extension uses the latched op and addr[1:0].

Test Plan:
- lw addr 0x00000010, ack on first REQ cycle, rdata 0x12345678 -> bus_be=1111, bus_we=0, M_stall high for exactly 2 cycles, M_dmData=0x12345678 in DONE.
- lb addr 0x00000013, rdata 0x80FF7F01, ack after 3 wait cycles -> M_dmData=0xFFFFFF80, 5 stall cycles; repeat with lbu -> 0x00000080.
- sh addr 0x00000022, rt=0xAAAA5A5A -> bus_we=1, bus_be=1100, bus_addr=0x00000020, bus_wdata=0x5A5A5A5A, M_dmData=0.
- lw addr 0x00000002 -> M_excAdEL=1, bus_req never asserted, M_stall=0; sh addr 0x1 -> M_excAdES=1.
- sw with ack never driven, BUS_TIMEOUT=16 -> bus_req drops after 16 REQ cycles, M_busErr=1 in DONE, returns to IDLE.
- Pull reset low 2 cycles into REQ, then pulse bus_ack while reset is low -> bus_req=0 immediately, M_stall=0, all outputs 0; after release the next lw completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access engine driving a req/ack bus.
// Ports: clk/reset, M_* pipeline inputs, bus_* data bus, M_stall/M_dmData/M_exc*/M_busErr.
module mem_access_unit #(
  parameter int unsigned BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_valid,
  input  logic [3:0]  M_memOp,
  input  logic [31:0] M_addr,
  input  logic [31:0] M_rtData,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        M_stall,
  output logic [31:0] M_dmData,
  output logic        M_excAdEL,
  output logic        M_excAdES,
  output logic        M_busErr
);

  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  localparam logic [7:0] CNT_LAST = 8'(BUS_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] dm_q, dm_d;
  logic        err_q, err_d;

  logic        is_ld;
  logic        is_st;
  logic        mis;
  logic [3:0]  be_new;
  logic [31:0] wd_new;
  logic        start;
  logic        ld_q;
  logic        timeout;
  logic [15:0] half;
  logic [7:0]  byte_s;
  logic [31:0] ext;

  always_comb begin
    is_ld  = 1'b0;
    is_st  = 1'b0;
    mis    = 1'b0;
    be_new = 4'hF;
    wd_new = M_rtData;
    unique case (M_memOp)
      OP_LW: begin
        is_ld = 1'b1;
        mis   = |M_addr[1:0];
      end
      OP_LH, OP_LHU: begin
        is_ld = 1'b1;
        mis   = M_addr[0];
      end
      OP_LB, OP_LBU: is_ld = 1'b1;
      OP_SW: begin
        is_st = 1'b1;
        mis   = |M_addr[1:0];
      end
      OP_SH: begin
        is_st  = 1'b1;
        mis    = M_addr[0];
        be_new = M_addr[1] ? 4'b1100 : 4'b0011;
        wd_new = {2{M_rtData[15:0]}};
      end
      OP_SB: begin
        is_st  = 1'b1;
        be_new = 4'b0001 << M_addr[1:0];
        wd_new = {4{M_rtData[7:0]}};
      end
      default: ;
    endcase
  end

  assign start     = M_valid & (is_ld | is_st) & ~mis & (state_q == IDLE);
  assign M_excAdEL = M_valid & is_ld & mis & (state_q == IDLE);
  assign M_excAdES = M_valid & is_st & mis & (state_q == IDLE);
  assign M_stall   = reset & (start | (state_q == REQ));

  assign ld_q    = (op_q >= OP_LW) && (op_q <= OP_LBU);
  assign timeout = (cnt_q == CNT_LAST);

  // Extension works from the op/offset latched at start, not live inputs.
  always_comb begin
    half   = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    byte_s = 8'h00;
    unique case (off_q)
      2'd0: byte_s = bus_rdata[7:0];
      2'd1: byte_s = bus_rdata[15:8];
      2'd2: byte_s = bus_rdata[23:16];
      2'd3: byte_s = bus_rdata[31:24];
      default: ;
    endcase
    ext = bus_rdata;
    unique case (op_q)
      OP_LH:   ext = {{16{half[15]}}, half};
      OP_LHU:  ext = {16'h0000, half};
      OP_LB:   ext = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  ext = {24'h000000, byte_s};
      default: ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = REQ;
      REQ:     if (bus_ack || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    op_d    = op_q;
    off_d   = off_q;
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dm_d    = dm_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          req_d   = 1'b1;
          we_d    = is_st;
          be_d    = be_new;
          addr_d  = {M_addr[31:2], 2'b00};
          wdata_d = wd_new;
          cnt_d   = 8'd0;
          op_d    = M_memOp;
          off_d   = M_addr[1:0];
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        // An ack on the timeout cycle still completes normally.
        if (bus_ack) begin
          req_d = 1'b0;
          dm_d  = ld_q ? ext : 32'h0;
          err_d = 1'b0;
        end else if (timeout) begin
          req_d = 1'b0;
          dm_d  = 32'h0;
          err_d = 1'b1;
        end
      end
      DONE: begin
        we_d = 1'b0;
        be_d = 4'h0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= 8'd0;
      op_q    <= 4'd0;
      off_q   <= 2'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      dm_q    <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      off_q   <= off_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dm_q    <= dm_d;
      err_q   <= err_d;
    end
  end

  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_be    = be_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign M_dmData  = dm_q;
  assign M_busErr  = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized transactions against a behavioural model,
// plus directed cases with literal expectations.
module tb_mem_access_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        M_valid;
  logic [3:0]  M_memOp;
  logic [31:0] M_addr;
  logic [31:0] M_rtData;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        M_stall;
  logic [31:0] M_dmData;
  logic        M_excAdEL;
  logic        M_excAdES;
  logic        M_busErr;

  mem_access_unit #(.BUS_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .M_valid(M_valid), .M_memOp(M_memOp),
    .M_addr(M_addr), .M_rtData(M_rtData),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .M_stall(M_stall),
    .M_dmData(M_dmData), .M_excAdEL(M_excAdEL),
    .M_excAdES(M_excAdES), .M_busErr(M_busErr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int stall_seen = 0;
  int req_seen = 0;

  logic        chk_en = 1'b0;
  logic        e_stall, e_req, e_el, e_es;
  logic        e_chk_bus, e_chk_wd, e_chk_idle, e_chk_dm;
  logic        e_we, e_err;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wdata, e_dm;
  logic [31:0] last_dm, last_addr, last_wdata;
  logic [3:0]  last_be;
  logic        last_err, last_we;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- behavioural model ----
  function automatic logic mdl_ld(input logic [3:0] op);
    return op >= 1 && op <= 5;
  endfunction

  function automatic logic mdl_st(input logic [3:0] op);
    return op >= 6 && op <= 8;
  endfunction

  function automatic logic mdl_mis(input logic [3:0] op, input logic [31:0] a);
    if (op == 1 || op == 6) return (a % 4) != 0;
    if (op == 2 || op == 3 || op == 7) return (a % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] mdl_be(input logic [3:0] op, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (op == 7) return (off >= 2) ? 4'b1100 : 4'b0011;
    if (op == 8) return 4'(1 << off);
    return 4'b1111;
  endfunction

  function automatic logic [31:0] mdl_wdata(input logic [3:0] op, input logic [31:0] rt);
    if (op == 7) return (rt & 32'hFFFF) * 32'h0001_0001;
    if (op == 8) return (rt & 32'hFF) * 32'h0101_0101;
    return rt;
  endfunction

  function automatic logic [31:0] mdl_ext(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] rd);
    logic [31:0] h, b;
    h = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    case (op)
      4'd2: return (h ^ 32'h8000) - 32'h8000;
      4'd3: return h;
      4'd4: return (b ^ 32'h80) - 32'h80;
      4'd5: return b;
      default: return rd;
    endcase
  endfunction

  // ---- single compare process ----
  always @(negedge clk) begin
    if (chk_en) begin
      if (M_stall) stall_seen++;
      if (bus_req) req_seen++;
      cmp("stall", M_stall, e_stall);
      cmp("bus_req", bus_req, e_req);
      cmp("excAdEL", M_excAdEL, e_el);
      cmp("excAdES", M_excAdES, e_es);
      if (e_chk_bus) begin
        cmp("bus_we", bus_we, e_we);
        cmp("bus_be", bus_be, e_be);
        cmp("bus_addr", bus_addr, e_addr);
      end
      if (e_chk_wd) cmp("bus_wdata", bus_wdata, e_wdata);
      if (e_chk_idle) begin
        cmp("idle_be", bus_be, 4'h0);
        cmp("idle_we", bus_we, 1'b0);
      end
      if (e_chk_dm) begin
        cmp("dmData", M_dmData, e_dm);
        cmp("busErr", M_busErr, e_err);
      end
    end
  end

  // wn: REQ cycle index of the ack; <0 or >=TO means no ack.
  task automatic xact(input logic [3:0] op, input logic [31:0] addr,
                      input logic [31:0] rt, input int wn,
                      input logic [31:0] rd);
    logic ld, st, mis, acked;
    ld  = mdl_ld(op);
    st  = mdl_st(op);
    mis = (ld || st) && mdl_mis(op, addr);
    @(posedge clk); #1;
    stall_seen = 0;
    req_seen   = 0;
    M_valid    = 1'b1;
    M_memOp    = op;
    M_addr     = addr;
    M_rtData   = rt;
    bus_ack    = 1'($urandom);
    bus_rdata  = $urandom;
    e_stall    = (ld || st) && !mis;
    e_req      = 1'b0;
    e_el       = ld && mis;
    e_es       = st && mis;
    e_chk_bus  = 1'b0;
    e_chk_wd   = 1'b0;
    e_chk_idle = 1'b1;
    e_chk_dm   = 1'b0;
    chk_en     = 1'b1;
    if (!e_stall) return;
    acked = 1'b0;
    for (int k = 0; k < TO; k++) begin
      @(posedge clk); #1;
      M_valid    = 1'($urandom);
      M_memOp    = 4'($urandom);
      M_addr     = $urandom;
      M_rtData   = $urandom;
      bus_ack    = (k == wn);
      bus_rdata  = (k == wn) ? rd : $urandom;
      e_stall    = 1'b1;
      e_req      = 1'b1;
      e_el       = 1'b0;
      e_es       = 1'b0;
      e_chk_idle = 1'b0;
      e_chk_bus  = 1'b1;
      e_chk_wd   = st;
      e_we       = st;
      e_be       = mdl_be(op, addr);
      e_addr     = addr & ~32'h3;
      e_wdata    = mdl_wdata(op, rt);
      if (k == wn) begin
        acked = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    bus_ack   = 1'($urandom);
    bus_rdata = $urandom;
    M_valid   = 1'($urandom);
    M_memOp   = 4'($urandom);
    M_addr    = $urandom;
    e_stall   = 1'b0;
    e_req     = 1'b0;
    e_el      = 1'b0;
    e_es      = 1'b0;
    e_chk_bus = 1'b0;
    e_chk_wd  = 1'b0;
    e_chk_dm  = 1'b1;
    e_dm      = (acked && ld) ? mdl_ext(op, addr, rd) : 32'h0;
    e_err     = !acked;
    @(negedge clk);
    last_dm    = M_dmData;
    last_err   = M_busErr;
    last_be    = bus_be;
    last_we    = bus_we;
    last_addr  = bus_addr;
    last_wdata = bus_wdata;
    M_valid    = 1'b0;
    bus_ack    = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    M_valid   = 1'b0;
    M_memOp   = 4'd0;
    M_addr    = 32'h0;
    M_rtData  = 32'h0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    #3;
    cmp("rst_req", bus_req, 1'b0);
    cmp("rst_stall", M_stall, 1'b0);
    cmp("rst_dm", M_dmData, 32'h0);
    cmp("rst_err", M_busErr, 1'b0);
    cmp("rst_be", bus_be, 4'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // pin the model itself
    cmp("mdl_lb", mdl_ext(4'd4, 32'h13, 32'h80FF7F01), 32'hFFFFFF80);
    cmp("mdl_lbu", mdl_ext(4'd5, 32'h13, 32'h80FF7F01), 32'h00000080);
    cmp("mdl_sh_be", mdl_be(4'd7, 32'h22), 4'b1100);
    cmp("mdl_sh_wd", mdl_wdata(4'd7, 32'hAAAA5A5A), 32'h5A5A5A5A);

    xact(4'd1, 32'h10, 32'h0, 0, 32'h12345678);
    cmp("lw_dm", last_dm, 32'h12345678);
    cmp("lw_stalls", stall_seen, 2);
    cmp("lw_be", last_be, 4'hF);
    cmp("lw_we", last_we, 1'b0);

    xact(4'd4, 32'h13, 32'h0, 3, 32'h80FF7F01);
    cmp("lb_dm", last_dm, 32'hFFFFFF80);
    cmp("lb_stalls", stall_seen, 5);
    xact(4'd5, 32'h13, 32'h0, 3, 32'h80FF7F01);
    cmp("lbu_dm", last_dm, 32'h00000080);

    xact(4'd7, 32'h22, 32'hAAAA5A5A, 1, 32'hDEADBEEF);
    cmp("sh_we", last_we, 1'b1);
    cmp("sh_be", last_be, 4'b1100);
    cmp("sh_addr", last_addr, 32'h20);
    cmp("sh_wdata", last_wdata, 32'h5A5A5A5A);
    cmp("sh_dm", last_dm, 32'h0);

    xact(4'd1, 32'h2, 32'h0, 0, 32'h0);
    @(negedge clk);
    cmp("mis_lw_el", M_excAdEL, 1'b1);
    cmp("mis_lw_req", req_seen, 0);
    xact(4'd7, 32'h1, 32'h0, 0, 32'h0);
    @(negedge clk);
    cmp("mis_sh_es", M_excAdES, 1'b1);

    xact(4'd6, 32'h40, 32'h11223344, -1, 32'h0);
    cmp("to_err", last_err, 1'b1);
    cmp("to_req_cycles", req_seen, TO);
    cmp("to_stalls", stall_seen, TO + 1);

    xact(4'd2, 32'h6, 32'h0, TO - 1, 32'h8001_7FFF);
    cmp("ack_wins_err", last_err, 1'b0);
    cmp("ack_wins_dm", last_dm, 32'hFFFF8001);

    // reset in the middle of an access
    @(posedge clk); #1;
    chk_en   = 1'b0;
    M_valid  = 1'b1;
    M_memOp  = 4'd1;
    M_addr   = 32'h80;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cmp("pre_rst_req", bus_req, 1'b1);
    reset = 1'b0;
    #1;
    cmp("mr_req", bus_req, 1'b0);
    cmp("mr_stall", M_stall, 1'b0);
    cmp("mr_be", bus_be, 4'h0);
    cmp("mr_addr", bus_addr, 32'h0);
    cmp("mr_dm", M_dmData, 32'h0);
    bus_ack   = 1'b1;
    bus_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(posedge clk); #1;
    cmp("mr_req2", bus_req, 1'b0);
    cmp("mr_dm2", M_dmData, 32'h0);
    M_valid = 1'b0;
    reset   = 1'b1;
    xact(4'd1, 32'h44, 32'h0, 2, 32'hCAFEF00D);
    cmp("post_rst_dm", last_dm, 32'hCAFEF00D);

    for (int i = 0; i < 300; i++) begin
      logic [3:0]  op;
      logic [31:0] a;
      int          r, wn;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      r  = int'($urandom_range(0, 9));
      if (r == 0)      wn = -1;
      else if (r == 1) wn = TO - 1;
      else             wn = int'($urandom_range(0, 4));
      xact(op, a, $urandom, wn, $urandom);
    end

    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
